// File: rtl/cp0_regs_pkg.sv
// Shared CPU defines: committed exception codes, CP0 ExcCode values and CP0 register addresses.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cp0_regs_pkg;

  // Exception type presented by the MEM-stage prioritiser.
  typedef enum logic [4:0] {
    EX_None                 = 5'd0,
    EX_Interrupt            = 5'd1,
    EX_TLBModified          = 5'd2,
    EX_IF_TLBRefill         = 5'd3,
    EX_IF_TLBInvalid        = 5'd4,
    EX_Rd_TLBRefill         = 5'd5,
    EX_Rd_TLBInvalid        = 5'd6,
    EX_Wr_TLBRefill         = 5'd7,
    EX_Wr_TLBInvalid        = 5'd8,
    EX_WrongAddressinIF     = 5'd9,
    EX_RdWrongAddressinMEM  = 5'd10,
    EX_WrWrongAddressinMEM  = 5'd11,
    EX_Syscall              = 5'd12,
    EX_Break                = 5'd13,
    EX_ReservedInstruction  = 5'd14,
    EX_CpU                  = 5'd15,
    EX_Overflow             = 5'd16,
    EX_Trap                 = 5'd17,
    EX_Eret                 = 5'd18,
    EX_Refetch              = 5'd19
  } ex_type_e;

  // Cause.ExcCode values.
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_CPU  = 5'h0B;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_TR   = 5'h0D;

  // CP0 register numbers and selects.
  localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ADDR_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_ADDR_STATUS   = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;
  localparam logic [4:0] CP0_ADDR_EBASE    = 5'd15;
  localparam logic [2:0] CP0_SEL_0         = 3'd0;
  localparam logic [2:0] CP0_SEL_1         = 3'd1;

  // True for codes that enter exception level (everything but None/Refetch/Eret).
  function automatic logic is_exception(input ex_type_e ex);
    case (ex)
      EX_None, EX_Refetch, EX_Eret: is_exception = 1'b0;
      EX_Interrupt, EX_TLBModified, EX_IF_TLBRefill, EX_IF_TLBInvalid,
      EX_Rd_TLBRefill, EX_Rd_TLBInvalid, EX_Wr_TLBRefill, EX_Wr_TLBInvalid,
      EX_WrongAddressinIF, EX_RdWrongAddressinMEM, EX_WrWrongAddressinMEM,
      EX_Syscall, EX_Break, EX_ReservedInstruction, EX_CpU, EX_Overflow,
      EX_Trap: is_exception = 1'b1;
      default: is_exception = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] exc_code(input ex_type_e ex);
    case (ex)
      EX_TLBModified:                          exc_code = EXC_MOD;
      EX_IF_TLBRefill, EX_IF_TLBInvalid,
      EX_Rd_TLBRefill, EX_Rd_TLBInvalid:       exc_code = EXC_TLBL;
      EX_Wr_TLBRefill, EX_Wr_TLBInvalid:       exc_code = EXC_TLBS;
      EX_WrongAddressinIF,
      EX_RdWrongAddressinMEM:                  exc_code = EXC_ADEL;
      EX_WrWrongAddressinMEM:                  exc_code = EXC_ADES;
      EX_Syscall:                              exc_code = EXC_SYS;
      EX_Break:                                exc_code = EXC_BP;
      EX_ReservedInstruction:                  exc_code = EXC_RI;
      EX_CpU:                                  exc_code = EXC_CPU;
      EX_Overflow:                             exc_code = EXC_OV;
      EX_Trap:                                 exc_code = EXC_TR;
      default:                                 exc_code = EXC_INT;
    endcase
  endfunction

  // Address-related faults capture the faulting address into BadVAddr.
  function automatic logic loads_badvaddr(input ex_type_e ex);
    case (ex)
      EX_TLBModified, EX_IF_TLBRefill, EX_IF_TLBInvalid, EX_Rd_TLBRefill,
      EX_Rd_TLBInvalid, EX_Wr_TLBRefill, EX_Wr_TLBInvalid, EX_WrongAddressinIF,
      EX_RdWrongAddressinMEM, EX_WrWrongAddressinMEM: loads_badvaddr = 1'b1;
      default:                                        loads_badvaddr = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clk, TI latches on a Count==Compare hit.
// Latency: writes and TI visible the cycle after the edge.
// Backpressure: none; writes always accepted.
// Ports: count_we_i/compare_we_i with wr_data_i load the registers; count_o, compare_o, ti_o report state.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        toggle_q, toggle_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    toggle_d  = ~toggle_q;
    ti_d      = ti_q;
    // Increment on the second cycle of each toggle pair; wraps naturally.
    if (toggle_q) count_d = count_q + 32'd1;
    if (count_we_i) begin
      count_d  = wr_data_i;
      toggle_d = 1'b0;
    end
    // Compare == 0 is treated as "timer disarmed".
    if ((compare_q != 32'd0) && (count_q == compare_q)) ti_d = 1'b1;
    // A Compare write acknowledges the interrupt and beats a coincident hit.
    if (compare_we_i) begin
      compare_d = wr_data_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      toggle_q  <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: exception commit, mtc0/mfc0 access, interrupt request generation.
// Latency: state updates visible one cycle after the edge; mfc0 read is combinational.
// Backpressure: none; a committed exception drops a same-cycle mtc0.
// Ports: MEM_* exception commit inputs, Ext_Int lines, CP0_We/WrAddr/WrSel/WrData write port,
//        CP0_RdAddr/RdSel/RdData read port, Status/EBase/EPC/MEM_Interrupt status outputs.
module cp0_regs
  import cp0_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  MEM_ExcType,
  input  logic [31:0] MEM_PC,
  input  logic        MEM_IsInDelaySlot,
  input  logic [31:0] MEM_BadVAddr,
  input  logic [5:0]  Ext_Int,
  input  logic        CP0_We,
  input  logic [4:0]  CP0_WrAddr,
  input  logic [2:0]  CP0_WrSel,
  input  logic [31:0] CP0_WrData,
  input  logic [4:0]  CP0_RdAddr,
  input  logic [2:0]  CP0_RdSel,
  output logic [31:0] CP0_RdData,
  output logic        CP0_Status_BEV,
  output logic        CP0_Status_EXL,
  output logic [31:0] CP0_Ebase,
  output logic [31:0] CP0_EPC,
  output logic        MEM_Interrupt
);

  ex_type_e    ex;
  logic        exc_take, exc_eret, mtc0_en;

  logic        bev_q, bev_d, exl_q, exl_d, ie_q, ie_d;
  logic [7:0]  im_q, im_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [17:0] ebase_q, ebase_d;

  logic [31:0] count, compare;
  logic        ti;
  logic [31:0] status_w, cause_w, ebase_w;

  assign ex       = ex_type_e'(MEM_ExcType);
  assign exc_take = is_exception(ex);
  assign exc_eret = (ex == EX_Eret);
  // Any committed exception or eret flushes the instruction that issued the mtc0.
  assign mtc0_en  = CP0_We & ~exc_take & ~exc_eret;

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (mtc0_en && CP0_WrAddr == CP0_ADDR_COUNT   && CP0_WrSel == CP0_SEL_0),
    .compare_we_i (mtc0_en && CP0_WrAddr == CP0_ADDR_COMPARE && CP0_WrSel == CP0_SEL_0),
    .wr_data_i    (CP0_WrData),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  always_comb begin
    bev_d      = bev_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    im_d       = im_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ebase_d    = ebase_q;
    // Hardware interrupt pending bits are resampled every cycle; IP7 shares the timer.
    ip_hw_d    = {Ext_Int[5] | ti, Ext_Int[4:0]};

    if (exc_take) begin
      exl_d     = 1'b1;
      exccode_d = exc_code(ex);
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        bd_d  = MEM_IsInDelaySlot;
        epc_d = MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
      end
      if (loads_badvaddr(ex)) badvaddr_d = MEM_BadVAddr;
    end else if (exc_eret) begin
      exl_d = 1'b0;
    end else if (CP0_We) begin
      case ({CP0_WrAddr, CP0_WrSel})
        {CP0_ADDR_STATUS, CP0_SEL_0}: begin
          bev_d = CP0_WrData[22];
          im_d  = CP0_WrData[15:8];
          exl_d = CP0_WrData[1];
          ie_d  = CP0_WrData[0];
        end
        {CP0_ADDR_CAUSE, CP0_SEL_0}: ip_sw_d = CP0_WrData[9:8];
        {CP0_ADDR_EPC,   CP0_SEL_0}: epc_d   = CP0_WrData;
        {CP0_ADDR_EBASE, CP0_SEL_1}: ebase_d = CP0_WrData[29:12];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bev_q      <= 1'b1;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      im_q       <= '0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      ebase_q    <= '0;
    end else begin
      bev_q      <= bev_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      ebase_q    <= ebase_d;
    end
  end

  assign status_w = {9'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_w  = {bd_q, ti, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
  assign ebase_w  = {2'b10, ebase_q, 12'b0};

  always_comb begin
    CP0_RdData = '0;
    case ({CP0_RdAddr, CP0_RdSel})
      {CP0_ADDR_BADVADDR, CP0_SEL_0}: CP0_RdData = badvaddr_q;
      {CP0_ADDR_COUNT,    CP0_SEL_0}: CP0_RdData = count;
      {CP0_ADDR_COMPARE,  CP0_SEL_0}: CP0_RdData = compare;
      {CP0_ADDR_STATUS,   CP0_SEL_0}: CP0_RdData = status_w;
      {CP0_ADDR_CAUSE,    CP0_SEL_0}: CP0_RdData = cause_w;
      {CP0_ADDR_EPC,      CP0_SEL_0}: CP0_RdData = epc_q;
      {CP0_ADDR_EBASE,    CP0_SEL_1}: CP0_RdData = ebase_w;
      default:                        CP0_RdData = '0;
    endcase
  end

  assign CP0_Status_BEV = bev_q;
  assign CP0_Status_EXL = exl_q;
  assign CP0_Ebase      = ebase_w;
  assign CP0_EPC        = epc_q;
  assign MEM_Interrupt  = ie_q & ~exl_q & |({ip_hw_q, ip_sw_q} & im_q);

endmodule

// File: tb/tb_cp0_regs.sv
module tb_cp0_regs;
  import cp0_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  MEM_ExcType = 5'd0;
  logic [31:0] MEM_PC = '0;
  logic        MEM_IsInDelaySlot = 1'b0;
  logic [31:0] MEM_BadVAddr = '0;
  logic [5:0]  Ext_Int = '0;
  logic        CP0_We = 1'b0;
  logic [4:0]  CP0_WrAddr = '0;
  logic [2:0]  CP0_WrSel = '0;
  logic [31:0] CP0_WrData = '0;
  logic [4:0]  CP0_RdAddr = '0;
  logic [2:0]  CP0_RdSel = '0;
  logic [31:0] CP0_RdData;
  logic        CP0_Status_BEV, CP0_Status_EXL, MEM_Interrupt;
  logic [31:0] CP0_Ebase, CP0_EPC;

  cp0_regs dut (
    .clk(clk), .rst(rst),
    .MEM_ExcType(MEM_ExcType), .MEM_PC(MEM_PC), .MEM_IsInDelaySlot(MEM_IsInDelaySlot),
    .MEM_BadVAddr(MEM_BadVAddr), .Ext_Int(Ext_Int),
    .CP0_We(CP0_We), .CP0_WrAddr(CP0_WrAddr), .CP0_WrSel(CP0_WrSel), .CP0_WrData(CP0_WrData),
    .CP0_RdAddr(CP0_RdAddr), .CP0_RdSel(CP0_RdSel), .CP0_RdData(CP0_RdData),
    .CP0_Status_BEV(CP0_Status_BEV), .CP0_Status_EXL(CP0_Status_EXL),
    .CP0_Ebase(CP0_Ebase), .CP0_EPC(CP0_EPC), .MEM_Interrupt(MEM_Interrupt)
  );

  always #5 clk = ~clk;

  localparam int K_REG = 0, K_INT = 1, K_EXL = 2, K_BEV = 3, K_EBASE = 4, K_EPC = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [4:0]  addr;
    logic [2:0]  sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  logic mon_busy = 1'b0;

  // Monitor: on each falling edge, pop every pending expectation and compare.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        mon_busy = 1'b1;
        c = sb_q.pop_front();
        act = '0;
        case (c.kind)
          K_REG: begin
            CP0_RdAddr = c.addr;
            CP0_RdSel  = c.sel;
            #1;
            act = CP0_RdData;
          end
          K_INT:   act = {31'b0, MEM_Interrupt};
          K_EXL:   act = {31'b0, CP0_Status_EXL};
          K_BEV:   act = {31'b0, CP0_Status_BEV};
          K_EBASE: act = CP0_Ebase;
          default: act = CP0_EPC;
        endcase
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic chk_reg(input string name, input logic [4:0] a, input logic [2:0] s,
                         input logic [31:0] exp);
    chk_t c;
    c.name = name; c.kind = K_REG; c.addr = a; c.sel = s; c.exp = exp;
    sb_q.push_back(c);
  endtask

  task automatic chk_sig(input string name, input int kind, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.addr = '0; c.sel = '0; c.exp = exp;
    sb_q.push_back(c);
  endtask

  // Wait (bounded) for the monitor to consume everything queued.
  task automatic flush();
    for (int i = 0; i < 200 && (sb_q.size() != 0 || mon_busy); i++) #1;
    if (sb_q.size() != 0 || mon_busy) begin
      total++;
      bad++;
      $display("FAIL monitor_timeout: pending=%0d expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic cyc();
    flush();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    flush();
    CP0_We = 1'b1; CP0_WrAddr = a; CP0_WrSel = s; CP0_WrData = d;
    @(posedge clk);
    #1;
    CP0_We = 1'b0;
  endtask

  task automatic exc(input ex_type_e t, input logic [31:0] pc, input logic ds,
                     input logic [31:0] bva);
    flush();
    MEM_ExcType = t; MEM_PC = pc; MEM_IsInDelaySlot = ds; MEM_BadVAddr = bva;
    @(posedge clk);
    #1;
    MEM_ExcType = EX_None; MEM_IsInDelaySlot = 1'b0;
  endtask

  initial begin
    // Reset state (held in reset)
    #2;
    chk_reg("rst_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_0000);
    chk_reg("rst_cause",  CP0_ADDR_CAUSE,  CP0_SEL_0, 32'h0000_0000);
    chk_reg("rst_ebase",  CP0_ADDR_EBASE,  CP0_SEL_1, 32'h8000_0000);
    flush();
    chk_reg("rst_count",  CP0_ADDR_COUNT,  CP0_SEL_0, 32'h0000_0000);
    chk_sig("rst_int", K_INT, 32'd0);
    chk_sig("rst_bev", K_BEV, 32'd1);
    chk_sig("rst_epc", K_EPC, 32'd0);
    flush();
    rst = 1'b0;
    cyc();

    // Syscall in delay slot, EXL=0
    exc(EX_Syscall, 32'hBFC0_0380, 1'b1, 32'h1234_5678);
    chk_sig("sys_epc", K_EPC, 32'hBFC0_037C);
    chk_reg("sys_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h8000_0020);
    chk_reg("sys_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_0002);
    chk_reg("sys_badva", CP0_ADDR_BADVADDR, CP0_SEL_0, 32'h0000_0000);

    // Nested overflow keeps EPC/BD, then eret
    exc(EX_Overflow, 32'h8000_1000, 1'b0, 32'h0);
    chk_reg("ov_epc", CP0_ADDR_EPC, CP0_SEL_0, 32'hBFC0_037C);
    chk_reg("ov_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h8000_0030);
    chk_sig("ov_exl", K_EXL, 32'd1);
    exc(EX_Eret, 32'h0, 1'b0, 32'h0);
    chk_reg("eret_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_0000);
    chk_reg("eret_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h8000_0030);
    chk_sig("eret_epc", K_EPC, 32'hBFC0_037C);

    // Store address error
    exc(EX_WrWrongAddressinMEM, 32'h8000_2000, 1'b0, 32'h8000_0003);
    chk_reg("ades_badva", CP0_ADDR_BADVADDR, CP0_SEL_0, 32'h8000_0003);
    chk_reg("ades_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0014);
    chk_sig("ades_epc", K_EPC, 32'h8000_2000);
    exc(EX_Eret, 32'h0, 1'b0, 32'h0);
    chk_sig("ades_eret_exl", K_EXL, 32'd0);

    // Refetch changes nothing
    exc(EX_Refetch, 32'h9000_0000, 1'b1, 32'hDEAD_BEEF);
    chk_sig("refetch_epc", K_EPC, 32'h8000_2000);
    chk_reg("refetch_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_0000);
    chk_reg("refetch_badva", CP0_ADDR_BADVADDR, CP0_SEL_0, 32'h8000_0003);

    // Break and Status mtc0 in the same cycle: the write is dropped
    flush();
    CP0_We = 1'b1; CP0_WrAddr = CP0_ADDR_STATUS; CP0_WrSel = CP0_SEL_0; CP0_WrData = 32'h0000_0001;
    exc(EX_Break, 32'h8000_3000, 1'b0, 32'h0);
    CP0_We = 1'b0;
    chk_reg("brk_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_0002);
    chk_reg("brk_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);
    exc(EX_Eret, 32'h0, 1'b0, 32'h0);
    chk_reg("brk_eret_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_0000);

    // Write masks
    wr(CP0_ADDR_STATUS, CP0_SEL_0, 32'hFFFF_FFFC);
    chk_reg("mask_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_FF00);
    chk_sig("mask_int_ie0", K_INT, 32'd0);
    wr(CP0_ADDR_CAUSE, CP0_SEL_0, 32'hFFFF_FFFF);
    chk_reg("mask_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0324);
    wr(CP0_ADDR_EBASE, CP0_SEL_1, 32'hFFFF_FFFF);
    chk_reg("mask_ebase", CP0_ADDR_EBASE, CP0_SEL_1, 32'hBFFF_F000);
    chk_sig("mask_ebase_out", K_EBASE, 32'hBFFF_F000);
    chk_reg("prid_sel0", CP0_ADDR_EBASE, CP0_SEL_0, 32'h0000_0000);
    wr(5'd7, CP0_SEL_0, 32'hFFFF_FFFF);
    chk_reg("unimpl_rd", 5'd7, CP0_SEL_0, 32'h0000_0000);

    // Software interrupt through IP0
    wr(CP0_ADDR_STATUS, CP0_SEL_0, 32'h0000_0101);
    chk_sig("swint_int", K_INT, 32'd1);
    chk_sig("swint_bev", K_BEV, 32'd0);
    wr(CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0000);
    chk_sig("swint_clr_int", K_INT, 32'd0);
    chk_reg("swint_clr_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);

    // External interrupt on IP2
    flush();
    Ext_Int = 6'b00_0001;
    wr(CP0_ADDR_STATUS, CP0_SEL_0, 32'h0000_0401);
    chk_reg("ext_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0424);
    chk_sig("ext_int", K_INT, 32'd1);
    Ext_Int = 6'b00_0000;
    cyc();
    chk_reg("ext_clr_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);
    chk_sig("ext_clr_int", K_INT, 32'd0);

    // Timer
    wr(CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_8000);
    wr(CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_0000);
    wr(CP0_ADDR_COMPARE, CP0_SEL_0, 32'h0000_0010);
    for (int i = 0; i < 30; i++) cyc();
    chk_reg("tmr_count31", CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_000F);
    chk_reg("tmr_cause31", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);
    cyc();
    chk_reg("tmr_count32", CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_0010);
    chk_reg("tmr_cause32", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);
    cyc();
    chk_reg("tmr_ti", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h4000_0024);
    cyc();
    chk_reg("tmr_ip7", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h4000_8024);
    chk_sig("tmr_int_ie0", K_INT, 32'd0);
    wr(CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_8001);
    chk_sig("tmr_int_ie1", K_INT, 32'd1);
    wr(CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_8003);
    chk_sig("tmr_int_exl1", K_INT, 32'd0);
    wr(CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_8000);
    wr(CP0_ADDR_COMPARE, CP0_SEL_0, 32'h0000_0010);
    chk_reg("tmr_ack_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_8024);
    cyc();
    chk_reg("tmr_ack_cause2", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);

    // Compare write coincident with a hit: the write wins
    wr(CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_0050);
    wr(CP0_ADDR_COMPARE, CP0_SEL_0, 32'h0000_0050);
    wr(CP0_ADDR_COMPARE, CP0_SEL_0, 32'h0000_0050);
    chk_reg("hitwr_cause", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);
    chk_reg("hitwr_count", CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_0051);
    cyc();
    chk_reg("hitwr_cause2", CP0_ADDR_CAUSE, CP0_SEL_0, 32'h0000_0024);

    // Count wrap
    wr(CP0_ADDR_COUNT, CP0_SEL_0, 32'hFFFF_FFFF);
    cyc();
    chk_reg("wrap_hold", CP0_ADDR_COUNT, CP0_SEL_0, 32'hFFFF_FFFF);
    cyc();
    chk_reg("wrap_zero", CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_0000);

    // Asynchronous reset between edges
    wr(CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_1234);
    chk_reg("pre_rst_count", CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_1234);
    cyc();
    rst = 1'b1;
    chk_reg("arst_count", CP0_ADDR_COUNT, CP0_SEL_0, 32'h0000_0000);
    chk_reg("arst_status", CP0_ADDR_STATUS, CP0_SEL_0, 32'h0040_0000);
    chk_sig("arst_ebase", K_EBASE, 32'h8000_0000);
    chk_sig("arst_int", K_INT, 32'd0);
    flush();
    rst = 1'b0;
    cyc();
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
